// File: rtl/enemy_sprite.sv
// One falling enemy: spawn delay, descent at difficulty speed, blink-out on hit, escape pulse.
// Optional macro ENEMY_LFSR_SPAWN_EN selects a pseudo-random spawn column instead of SPAWN_X.
module enemy_sprite #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter logic [11:0] COLOR       = 12'hF00,
    parameter int          SCREEN_H    = 480,
    parameter int          SPAWN_X     = 304,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          SPAWN_DELAY = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        frame_tick,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        hit,
    output logic [11:0] pixel,
    output logic        escaped,
    output logic        alive
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DYING  = 2'd3;

    localparam int DW = $clog2(SPAWN_DELAY + 1);

    logic [1:0]    fsm;
    logic [9:0]    x;
    logic [10:0]   y;
    logic [DW-1:0] delay_cnt;
    logic [3:0]    blink_cnt;
    logic [9:0]    spawn_x;

    logic          play;
    logic [10:0]   y_next;
    logic          off_screen;
    logic          in_box;
    logic          draw;

`ifdef ENEMY_LFSR_SPAWN_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16/14/13/11, free-running so spawn columns decorrelate across instances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign spawn_x = {1'b0, lfsr[8:0]} + 10'd64;
`else
    assign spawn_x = 10'(SPAWN_X);
`endif

    always_comb begin
        play       = (state >= 4'd1) && (state <= 4'd4);
        // state code 1..4 is directly the descent speed in lines per frame
        y_next     = y + {8'd0, state[2:0]};
        off_screen = (y_next >= 11'(SCREEN_H));
        in_box     = valid
                  && ({2'b0, h_cnt} >= {2'b0, x})
                  && ({2'b0, h_cnt} <  {2'b0, x} + 12'(SPRITE_W))
                  && ({2'b0, v_cnt} >= {1'b0, y})
                  && ({2'b0, v_cnt} <  {1'b0, y} + 12'(SPRITE_H));
        draw       = 1'b0;
        if (play) begin
            case (fsm)
                S_ACTIVE: draw = in_box;
                S_DYING:  draw = in_box && !blink_cnt[1];
                default:  draw = 1'b0;
            endcase
        end
    end

    assign alive = (fsm == S_ACTIVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= S_IDLE;
            x         <= '0;
            y         <= '0;
            delay_cnt <= '0;
            blink_cnt <= '0;
            escaped   <= 1'b0;
        end else begin
            escaped <= 1'b0;
            if (!play) begin
                fsm       <= S_IDLE;
                x         <= '0;
                y         <= '0;
                delay_cnt <= '0;
                blink_cnt <= '0;
            end else begin
                case (fsm)
                    S_IDLE: begin
                        fsm       <= S_WAIT;
                        delay_cnt <= DW'(SPAWN_DELAY);
                    end
                    S_WAIT: begin
                        if (frame_tick) begin
                            delay_cnt <= delay_cnt - 1'b1;
                            if (delay_cnt == DW'(1)) begin
                                fsm <= S_ACTIVE;
                                x   <= spawn_x;
                                y   <= '0;
                            end
                        end
                    end
                    S_ACTIVE: begin
                        // a hit beats an escape landing on the same tick
                        if (hit) begin
                            fsm       <= S_DYING;
                            blink_cnt <= 4'd15;
                        end else if (frame_tick) begin
                            if (off_screen) begin
                                escaped   <= 1'b1;
                                fsm       <= S_WAIT;
                                delay_cnt <= DW'(SPAWN_DELAY);
                            end else begin
                                y <= y_next;
                            end
                        end
                    end
                    default: begin
                        if (frame_tick) begin
                            if (blink_cnt == 4'd0) begin
                                fsm       <= S_WAIT;
                                delay_cnt <= DW'(SPAWN_DELAY);
                            end else begin
                                blink_cnt <= blink_cnt - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pixel <= 12'h000;
        else
            pixel <= draw ? COLOR : 12'h000;
    end

endmodule

// File: doc/enemy_sprite.md
# enemy_sprite

Generates one falling enemy's 12-bit pixel stream for the compositor's `enemy0/1/2` inputs. Each enemy appears after a spawn delay, descends at a speed set by the difficulty state, blinks and retires when hit, and raises an escape pulse when it leaves the bottom of the screen. Three instances, with different seeds, feed the compositor. Colour `12'h000` means transparent.

## Interface
- `SPRITE_W`, 32: sprite width in pixels. Must be ≤ 64.
- `SPRITE_H`, 32: sprite height in pixels.
- `COLOR`, 12'hF00: sprite colour. Must be nonzero.
- `SCREEN_H`, 480: visible lines.
- `SPAWN_X`, 304: fixed spawn column, used when the LFSR spawn feature is compiled out.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.
- `SPAWN_DELAY`, 60: frames spent in WAIT before each spawn. Must be ≥ 1.
- `clk  in  1`: pixel clock.
- `rst  in  1`: asynchronous, active-low reset.
- `state  in  4`: game state. 0 = GAMESTART, 1 = EASY, 2 = NORMAL, 3 = HARD, 4 = INFERNO, 5 = FAILURE.
- `frame_tick  in  1`: one-cycle pulse, once per frame, during vertical blank.
- `h_cnt  in  10`: current pixel column.
- `v_cnt  in  10`: current pixel line.
- `valid  in  1`: display-active flag.
- `hit  in  1`: player shot hit this enemy. Level input, sampled every clock.
- `pixel  out  12`: sprite colour or 12'h000.
- `escaped  out  1`: one-cycle pulse when the enemy leaves the screen.
- `alive  out  1`: high in ACTIVE only.

## Operation
- **Play states:** `state` values 1–4. Any other value is a non-play state.
- **FSM states:** IDLE, WAIT, ACTIVE, DYING.
- **IDLE:**
  - Entered from any FSM state on the clock where `state` is a non-play value. This takes priority over all other transitions.
  - In IDLE, `pixel` = 0 and the counters are cleared.
  - Exits to WAIT when `state` becomes a play value. On entry to WAIT, `delay_cnt` = SPAWN_DELAY.
- **WAIT:**
  - Each `frame_tick` decrements `delay_cnt`.
  - On the tick where `delay_cnt` == 1: go to ACTIVE, set y = 0 and x = the spawn column.
- **ACTIVE:**
  - Speed by state: EASY 1, NORMAL 2, HARD 3, INFERNO 4 lines per frame. Speed is sampled at each tick.
  - On each `frame_tick`: if y + speed ≥ SCREEN_H, pulse `escaped`, go to WAIT and reload `delay_cnt`. Otherwise y ← y + speed.
  - y is held in 11 bits, so the sum cannot wrap.
  - `hit` high: go to DYING with `blink_cnt` = 15. Position is frozen.
  - If `hit` and an escaping tick occur in the same cycle, `hit` wins and no `escaped` pulse is generated.
- **DYING:**
  - Each `frame_tick` decrements `blink_cnt`.
  - On the tick at 0: go to WAIT and reload `delay_cnt`.
  - `hit` is ignored.
- **Drawing:**
  - Draw condition: `valid` && x ≤ h_cnt < x+SPRITE_W && y ≤ v_cnt < y+SPRITE_H.
  - In ACTIVE, draw when the condition holds.
  - In DYING, draw when the condition holds and `blink_cnt[1]` == 0.
  - Otherwise the output colour is 0.
- **Spawn column:** LFSR_SPAWN_EN controls this (see Configuration).
- **Reset values:**
  - `pixel` = 0, `escaped` = 0, `alive` = 0.
  - FSM = IDLE; x, y, `delay_cnt`, `blink_cnt` = 0; LFSR = LFSR_SEED.

## Timing
- `pixel` is registered, so it lags (`h_cnt`, `v_cnt`, `valid`) by exactly 1 clock. The compositor adds 1 more clock, so the scan counters must be delayed by 2 clocks at the display.
- Position updates only on `frame_tick`, during blanking, so no tearing occurs within a frame.
- `escaped` is high for exactly 1 clock, in the cycle after the escaping tick is sampled.
- `alive` rises the clock after the spawning tick. It falls the clock after a hit, an escape, or a non-play state is sampled.
- Spawn latency: exactly SPAWN_DELAY `frame_tick`s after entering WAIT.
- Asserting `rst` mid-frame forces all reset values immediately, without waiting for a clock edge.

## Configuration
- **`ENEMY_LFSR_SPAWN_EN` defined:**
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) advances every clock outside reset.
  - Spawn x = lfsr[8:0] + 64, giving the range 64..575.
- **Not defined:**
  - No LFSR is instantiated.
  - Spawn x = SPAWN_X on every spawn.

## Test plan
- Reset low, then release with `state` = 0 for 10 frames → `pixel` = 0, `alive` = 0, `escaped` = 0 throughout.
- `state` = 1 with SPAWN_DELAY = 60 (macro off) → `alive` rises after the 60th tick. The first frame draws 12'hF00 exactly at h 304..335, v 0..31, and nowhere else.
- `state` = 4 → y advances 4 per tick. On the 120th active tick (y = 476), `escaped` pulses once and the block returns to WAIT.
- Assert `hit` during ACTIVE at y = 100 → `alive` = 0 next clock. The sprite blinks at y = 100 (off for ticks with `blink_cnt[1]` set), and after 16 ticks the block is in WAIT.
- `hit` in the same cycle as the escaping tick → no `escaped` pulse, and the block enters DYING.
- `state` changed to 5 while in DYING → IDLE next clock and `pixel` = 0. With `ENEMY_LFSR_SPAWN_EN` defined, 100 spawns all have x in 64..575 and `pixel` is never nonzero outside the sprite box.
